// File: rtl/mem_dump_reader_pkg.sv
// ============================================================================
// mem_dump_pkg : shared FSM state type, FIFO depth and counter width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } dump_state_t;

  localparam int FIFO_DEPTH = 2;

  // Bits needed to hold any value 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_dump_reader_if.sv
// ============================================================================
// mem_dump_reader_if : valid/ready word stream from the dump reader to its sink
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_dump_reader_if #(
  parameter int WID_MEM = 8
);

  logic [WID_MEM-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_dump_reader_skid_fifo.sv
// ============================================================================
// mem_dump_skid_fifo : two-entry data+last FIFO absorbing the RAM read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_dump_skid_fifo
  import mem_dump_pkg::*;
#(
  parameter int WID_MEM = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WID_MEM-1:0] push_data,
  input  logic               push_last,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [WID_MEM-1:0] head_data,
  output logic               head_last
);

  logic [WID_MEM-1:0] r_data [FIFO_DEPTH];
  logic               r_last [FIFO_DEPTH];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_pop;

  assign w_pop = pop && (r_count != 2'd0);

  // The issuer never pushes into a full FIFO, so no full check is needed here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_wptr] <= push_data;
        r_last[r_wptr] <= push_last;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

  assign count     = r_count;
  assign head_data = r_data[r_rptr];
  assign head_last = r_last[r_rptr];

endmodule

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ============================================================================
// mem_dump_reader : sweeps a RAM address window and streams the words out;
// define MEM_DUMP_CSUM_EN to add a running 32-bit checksum output (csum).
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int WID_MEM   = 8,
  parameter int DEPTH_MEM = 16384,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        num_words,
  input  logic               abort,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] rdata,
  mem_dump_reader_if.master  ds,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef MEM_DUMP_CSUM_EN
  ,
  output logic [31:0]        csum
`endif
);

  localparam int                 c_cnt_w   = cnt_width(DEPTH_MEM);
  localparam logic [c_cnt_w-1:0] c_rem_one = c_cnt_w'(1);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("mem_dump_reader: only RD_LAT=1 is supported");
  end

  dump_state_t        r_state;
  dump_state_t        w_state_nxt;

  logic [31:0]        r_next_addr;
  logic [c_cnt_w-1:0] r_remaining;
  logic [31:0]        r_raddr;
  logic               r_inflight;
  logic               r_inflight_last;
  logic               r_err;

  logic               w_start_ok;
  logic               w_zero;
  logic [32:0]        w_end;
  logic               w_range_err;
  logic               w_active;
  logic               w_flush;
  logic               w_issue;
  logic [2:0]         w_occ;
  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;
  logic [1:0]         w_fifo_count;
  logic [WID_MEM-1:0] w_head_data;
  logic               w_head_last;

  assign w_start_ok  = start && (r_state == IDLE);
  assign w_zero      = (num_words == 32'd0);
  assign w_end       = {1'b0, base_addr} + {1'b0, num_words};
  assign w_range_err = (w_end > 33'(DEPTH_MEM));
  assign w_active    = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_flush     = abort && w_active;

  assign w_out_valid = (w_fifo_count != 2'd0);
  assign w_pop       = w_out_valid && ds.out_ready;
  assign w_occ       = {1'b0, w_fifo_count} + {2'b00, r_inflight};

  // Crediting this cycle's pop lets a word issue every cycle while the sink
  // keeps up, without ever exceeding the two FIFO slots.
  assign w_issue = (r_state == ISSUE) && !abort && (r_remaining != '0) &&
                   (w_occ < (3'(FIFO_DEPTH) + {2'b00, w_pop}));

  assign w_push = r_inflight && !w_flush;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (w_zero || w_range_err) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          w_state_nxt = FIN;
        end else if (w_issue && (r_remaining == c_rem_one)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          w_state_nxt = FIN;
        end else if (w_pop && w_head_last) begin
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ISSUE, DRAIN: busy = 1'b1;
      FIN:          done = 1'b1;
      default:      ;
    endcase
  end

  // ------------------------------------------------- address / in-flight ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_next_addr     <= 32'd0;
      r_remaining     <= '0;
      r_raddr         <= 32'd0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == c_rem_one);
      if (w_start_ok) begin
        r_err       <= !w_zero && w_range_err;
        r_next_addr <= base_addr;
        r_remaining <= (w_zero || w_range_err) ? '0 : num_words[c_cnt_w-1:0];
      end else if (w_issue) begin
        r_raddr     <= r_next_addr;
        r_next_addr <= r_next_addr + 32'd1;
        r_remaining <= r_remaining - c_rem_one;
      end
    end
  end

  // The RAM samples raddr at the end of the issue cycle, so the address is
  // presented in that same cycle and held otherwise.
  assign raddr = w_issue ? r_next_addr : r_raddr;
  assign err   = r_err;

  mem_dump_skid_fifo #(
    .WID_MEM (WID_MEM)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (rdata),
    .push_last (r_inflight_last),
    .pop       (w_pop),
    .flush     (w_flush),
    .count     (w_fifo_count),
    .head_data (w_head_data),
    .head_last (w_head_last)
  );

  assign ds.out_valid = w_out_valid;
  assign ds.out_data  = w_head_data;
  assign ds.out_last  = w_out_valid && w_head_last;

`ifdef MEM_DUMP_CSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csum <= 32'd0;
    end else if (w_start_ok) begin
      r_csum <= 32'd0;
    end else if (w_pop) begin
      r_csum <= r_csum + 32'(w_head_data);
    end
  end

  assign csum = r_csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// ============================================================================
// tb_mem_dump_reader : directed self-checking bench for mem_dump_reader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_dump_reader;
  import mem_dump_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] num_words;
  logic        abort;
  logic [31:0] raddr;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        err;
`ifdef MEM_DUMP_CSUM_EN
  logic [31:0] csum;
`endif

  mem_dump_reader_if #(.WID_MEM(8)) ds_if ();

  mem_dump_reader #(
    .WID_MEM   (8),
    .DEPTH_MEM (16384),
    .RD_LAT    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .abort     (abort),
    .raddr     (raddr),
    .rdata     (rdata),
    .ds        (ds_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MEM_DUMP_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  logic [7:0] mem [16384];
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         n_valid_cyc;
  logic [7:0] got      [$];
  logic       got_last [$];
  int         got_cyc  [$];
  logic       prev_stall;
  logic       prev_abort;
  logic [7:0] prev_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rdata <= mem[raddr[13:0]];
    cyc   <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [31:0] b, input logic [31:0] n);
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] last_at(input int i);
    return (i < got_last.size()) ? 32'(got_last[i]) : 32'hDEAD_BEEF;
  endfunction

  // Stream monitor: sampled mid-cycle, records handshakes and checks stall stability.
  initial begin
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !prev_abort) begin
          chk("stall_valid", 32'(ds_if.out_valid), 32'd1);
          chk("stall_data", 32'(ds_if.out_data), 32'(prev_data));
        end
        if (ds_if.out_valid) n_valid_cyc++;
        if (ds_if.out_valid && ds_if.out_ready) begin
          got.push_back(ds_if.out_data);
          got_last.push_back(ds_if.out_last);
          got_cyc.push_back(cyc);
        end
        prev_stall = ds_if.out_valid && !ds_if.out_ready;
        prev_data  = ds_if.out_data;
        prev_abort = abort;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int nv;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
    n_checks        = 0;
    n_fail          = 0;
    n_valid_cyc     = 0;
    cyc             = 0;
    reset           = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    base_addr       = 32'd0;
    num_words       = 32'd0;
    ds_if.out_ready = 1'b1;
    tick(3);

    // Reset values
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(ds_if.out_valid), 32'd0);
    chk("rst_last", 32'(ds_if.out_last), 32'd0);
    chk("rst_data", 32'(ds_if.out_data), 32'd0);
    chk("rst_raddr", raddr, 32'd0);
    reset = 1'b1;
    tick(2);

    // Full-rate 16-word dump from address 0
    got.delete(); got_last.delete(); got_cyc.delete();
    start_dump(32'd0, 32'd16);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 60);
    chk("t1_busy_fin", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_word", word_at(i), 32'(i));
      chk("t1_last", last_at(i), (i == 15) ? 32'd1 : 32'd0);
    end
    chk("t1_back2back", 32'((got_cyc.size() == 16) ? got_cyc[15] - got_cyc[0] : -1), 32'd15);
    chk("t1_done_lat", 32'((got_cyc.size() == 16) ? cyc - got_cyc[15] : -1), 32'd1);
`ifdef MEM_DUMP_CSUM_EN
    chk("t1_csum", csum, 32'd120);
`endif
    tick(1);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Window ending at the last RAM word, ready toggling every cycle
    got.delete(); got_last.delete(); got_cyc.delete();
    start_dump(32'd16380, 32'd4);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      ds_if.out_ready = ~ds_if.out_ready;
      tick(1);
      k++;
    end
    chk("t2_done", 32'(done), 32'd1);
    ds_if.out_ready = 1'b1;
    chk("t2_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_word", word_at(i), 32'(8'hFC + i));
      chk("t2_last", last_at(i), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t2_raddr_end", raddr, 32'd16383);
    tick(2);

    // Out-of-range window: error, done, no words; next good start clears err
    got.delete(); got_last.delete(); got_cyc.delete();
    nv = n_valid_cyc;
    start_dump(32'd16383, 32'd2);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    tick(1);
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_err_sticky", 32'(err), 32'd1);
    chk("t3_no_valid", 32'(n_valid_cyc - nv), 32'd0);
    start_dump(32'd0, 32'd1);
    chk("t3_err_clear", 32'(err), 32'd0);
    wait_done("t3_done2", 20);
    chk("t3_count2", 32'(got.size()), 32'd1);
    chk("t3_word2", word_at(0), 32'd0);
    chk("t3_last2", last_at(0), 32'd1);
    tick(2);

    // Abort after 10 delivered words
    got.delete(); got_last.delete(); got_cyc.delete();
    start_dump(32'd0, 32'd100);
    k = 0;
    while (got.size() < 10 && k < 50) begin
      tick(1);
      k++;
    end
    chk("t4_reach10", 32'(got.size()), 32'd10);
    abort           = 1'b1;
    ds_if.out_ready = 1'b0;
    tick(1);
    abort           = 1'b0;
    chk("t4_valid_drop", 32'(ds_if.out_valid), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    ds_if.out_ready = 1'b1;
    tick(3);
    chk("t4_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("t4_word", word_at(i), 32'(i));
      chk("t4_last", last_at(i), 32'd0);
    end
`ifdef MEM_DUMP_CSUM_EN
    chk("t4_csum", csum, 32'd45);
`endif

    // Reset mid-dump, then a clean short dump
    got.delete(); got_last.delete(); got_cyc.delete();
    start_dump(32'd0, 32'd50);
    k = 0;
    while (got.size() < 5 && k < 40) begin
      tick(1);
      k++;
    end
    chk("t5_reach5", 32'(got.size()), 32'd5);
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_valid", 32'(ds_if.out_valid), 32'd0);
    chk("t5_last", 32'(ds_if.out_last), 32'd0);
    chk("t5_data", 32'(ds_if.out_data), 32'd0);
    chk("t5_raddr", raddr, 32'd0);
    tick(3);
    chk("t5_done_held", 32'(done), 32'd0);
    reset = 1'b1;
    tick(1);
    got.delete(); got_last.delete(); got_cyc.delete();
    start_dump(32'd0, 32'd3);
    wait_done("t5_done2", 20);
    chk("t5_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_word", word_at(i), 32'(i));
      chk("t5_lastf", last_at(i), (i == 2) ? 32'd1 : 32'd0);
    end
`ifdef MEM_DUMP_CSUM_EN
    chk("t5_csum", csum, 32'd3);
`endif
    tick(2);

    // Long backpressure: two words buffered, raddr frozen, start while busy ignored
    got.delete(); got_last.delete(); got_cyc.delete();
    ds_if.out_ready = 1'b0;
    start_dump(32'd32, 32'd8);
    tick(9);
    chk("t6_raddr_a", raddr, 32'd33);
    chk("t6_valid", 32'(ds_if.out_valid), 32'd1);
    chk("t6_head", 32'(ds_if.out_data), 32'h20);
    start_dump(32'd0, 32'd2);
    tick(9);
    chk("t6_raddr_b", raddr, 32'd33);
    chk("t6_head_b", 32'(ds_if.out_data), 32'h20);
    chk("t6_busy", 32'(busy), 32'd1);
    ds_if.out_ready = 1'b1;
    wait_done("t6_done", 40);
    chk("t6_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t6_word", word_at(i), 32'(32 + i));
      chk("t6_last", last_at(i), (i == 7) ? 32'd1 : 32'd0);
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
